viterbi_decision_out: RTL

Final decision stage of the Viterbi decoder. It sits directly downstream of the stage-2 butterfly edge modules and consumes their four end-state path metrics and path histories. It selects the survivor with the minimum signed metric through a two-level registered compare tree. The survivor's history is then shifted out one decoded bit per handshake, with last and error flags.

---
 rtl/viterbi_pkg.sv | 36 +++
 rtl/viterbi_min2.sv | 16 +
 rtl/viterbi_decision_out.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi decision output stage.
//   MW_DEF / HW_DEF : default metric and history widths
//   MW_MAX / HW_MAX : widths carried inside cand_t. Narrower metrics are
//                     sign-extended and narrower histories zero-extended.
//   state_e         : decision-stage FSM states
//   LBL_ONE/ZERO    : legal 2-bit branch labels
//   cand_t          : one survivor candidate {metric, history, idx}
//   decode_label    : maps a branch label to {bit, err}
package viterbi_pkg;

    localparam int MW_DEF = 8;
    localparam int HW_DEF = 6;
    localparam int MW_MAX = 32;
    localparam int HW_MAX = 32;

    typedef enum logic [1:0] {IDLE, CMP1, CMP2, SHIFT} state_e;

    localparam logic [1:0] LBL_ONE  = 2'b10;
    localparam logic [1:0] LBL_ZERO = 2'b01;

    typedef struct packed {
        logic signed [MW_MAX-1:0] metric;
        logic        [HW_MAX-1:0] history;
        logic        [1:0]        idx;
    } cand_t;

    // Returns {decoded_bit, illegal_label}
    function automatic logic [1:0] decode_label(input logic [1:0] lbl);
        case (lbl)
            LBL_ONE:  return 2'b10;
            LBL_ZERO: return 2'b00;
            default:  return 2'b01;
        endcase
    endfunction

endpackage

// File: rtl/viterbi_min2.sv
// Combinational signed compare-select of two survivor candidates.
// Strict less-than, so equal metrics keep the first operand (lower index).
//   a_i   : first candidate (lower state index)
//   b_i   : second candidate
//   win_o : candidate with the smaller signed metric
module viterbi_min2
    import viterbi_pkg::*;
(
    input  cand_t a_i,
    input  cand_t b_i,
    output cand_t win_o
);

    assign win_o = ($signed(b_i.metric) < $signed(a_i.metric)) ? b_i : a_i;

endmodule

// File: rtl/viterbi_decision_out.sv
// Final decision stage of the Viterbi decoder. Captures the four end-state
// metrics and histories, picks the minimum signed metric through a two-level
// registered compare tree, then streams the survivor history one decoded bit
// per handshake, oldest step first.
//
// Optional feature macro: DEC_METRIC_OUT_EN adds best_metric / best_idx.
//
// Ports:
//   CLK, RST_N                 clock, asynchronous active-low reset
//   END_00..END_11             signed end metrics of states 0..3
//   temp_c000..temp_c111       path histories of states 0..3
//   in_valid / in_ready        input set handshake
//   out_bit / out_valid /
//   out_ready                  decoded bit stream handshake
//   out_last                   bit is trellis step NB-1
//   out_err                    branch label was 2'b00 or 2'b11
//   best_metric, best_idx      winner metric/index (DEC_METRIC_OUT_EN only)
module viterbi_decision_out
    import viterbi_pkg::*;
#(
    parameter int MW = MW_DEF,
    parameter int HW = HW_DEF
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [MW-1:0] END_00,
    input  logic [MW-1:0] END_01,
    input  logic [MW-1:0] END_10,
    input  logic [MW-1:0] END_11,
    input  logic [HW-1:0] temp_c000,
    input  logic [HW-1:0] temp_c001,
    input  logic [HW-1:0] temp_c110,
    input  logic [HW-1:0] temp_c111,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          out_bit,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          out_err
`ifdef DEC_METRIC_OUT_EN
    ,
    output logic [MW-1:0] best_metric,
    output logic [1:0]    best_idx
`endif
);

    localparam int NB = HW / 2;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    state_e          state_q, state_d;
    cand_t [3:0]     in_q, in_d;
    cand_t           a_q, a_d, b_q, b_d;
    logic [HW-1:0]   sh_q, sh_d;
    logic [CW-1:0]   cnt_q, cnt_d;
`ifdef DEC_METRIC_OUT_EN
    logic [MW-1:0]   bm_q, bm_d;
    logic [1:0]      bi_q, bi_d;
`endif

    cand_t [3:0]     cand_in;
    cand_t           win_a, win_b, win_w;
    logic signed [MW-1:0] end_s [4];
    logic [HW-1:0]   hist_in [4];
    logic [1:0]      dec;
    logic            last_w;
    logic            unused_w;

    assign end_s[0]   = END_00;
    assign end_s[1]   = END_01;
    assign end_s[2]   = END_10;
    assign end_s[3]   = END_11;
    assign hist_in[0] = temp_c000;
    assign hist_in[1] = temp_c001;
    assign hist_in[2] = temp_c110;
    assign hist_in[3] = temp_c111;

    // Widen into the common candidate format; metrics keep their sign.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cand_in[i].metric  = MW_MAX'(end_s[i]);
            cand_in[i].history = HW_MAX'(hist_in[i]);
            cand_in[i].idx     = 2'(i);
        end
    end

    viterbi_min2 u_min_a (.a_i(in_q[0]), .b_i(in_q[1]), .win_o(win_a));
    viterbi_min2 u_min_b (.a_i(in_q[2]), .b_i(in_q[3]), .win_o(win_b));
    viterbi_min2 u_min_w (.a_i(a_q),     .b_i(b_q),     .win_o(win_w));

    // Only the history slice is needed when the metric outputs are absent.
    assign unused_w = ^win_w;

    assign dec    = decode_label(sh_q[HW-1 -: 2]);
    assign last_w = (cnt_q == CW'(NB - 1));

    assign out_bit  = (state_q == SHIFT) & dec[1];
    assign out_err  = (state_q == SHIFT) & dec[0];
    assign out_last = (state_q == SHIFT) & last_w;

    always_comb begin
        state_d   = state_q;
        in_d      = in_q;
        a_d       = a_q;
        b_d       = b_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
`ifdef DEC_METRIC_OUT_EN
        bm_d      = bm_q;
        bi_d      = bi_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    in_d    = cand_in;
                    state_d = CMP1;
                end
            end
            CMP1: begin
                a_d     = win_a;
                b_d     = win_b;
                state_d = CMP2;
            end
            CMP2: begin
                sh_d    = win_w.history[HW-1:0];
                cnt_d   = '0;
`ifdef DEC_METRIC_OUT_EN
                bm_d    = win_w.metric[MW-1:0];
                bi_d    = win_w.idx;
`endif
                state_d = SHIFT;
            end
            SHIFT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    sh_d  = sh_q << 2;
                    cnt_d = cnt_q + CW'(1);
                    if (last_w) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            in_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
`ifdef DEC_METRIC_OUT_EN
            bm_q    <= '0;
            bi_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            in_q    <= in_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
`ifdef DEC_METRIC_OUT_EN
            bm_q    <= bm_d;
            bi_q    <= bi_d;
`endif
        end
    end

`ifdef DEC_METRIC_OUT_EN
    assign best_metric = bm_q;
    assign best_idx    = bi_q;
`endif

endmodule
